ws2812_stream_driver: RTL and testbench
=======================================

WS2812_STREAM_DRIVER -- requirements
Module: ws2812_stream_driver

Interface
REQ-001 SHALL have parameter CLK_HZ, default 20000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BITS_PER_PIXEL, default 24, legal values 24 (GRB) or 32 (GRBW).
REQ-003 SHALL have parameter DEPTH, default 4, pixel FIFO depth; legal values 2..16, power of two.
REQ-004 SHALL have parameters T0H_NS, default 400; T1H_NS, default 800; PERIOD_NS, default 1250; RESET_US, default 300.
REQ-005 SHALL have port clk20, input, 1, sole clock, rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port data_in, input, BITS_PER_PIXEL, pixel word, transmitted MSB first.
REQ-008 SHALL have port latch_in, input, 1, marks the pixel as the last pixel of a frame.
REQ-009 SHALL have port valid, input, 1, data_in/latch_in qualifier.
REQ-010 SHALL have port ready, output, 1, high while FIFO not full.
REQ-011 SHALL have port led, output, 1, registered serial line to strip.
REQ-012 SHALL have port busy, output, 1, high whenever state is not IDLE or FIFO is non-empty.
REQ-013 SHALL have port underrun, output, 1, one-cycle pulse, FIFO empty mid-frame.
REQ-014 SHALL have port brightness, input, 8, global scale; present only with WS2812_BRIGHTNESS_EN.

Function
REQ-015 SHALL derive cycle counts by floor: CYC_P=CLK_HZ*PERIOD_NS/1e9, CYC_0H, CYC_1H likewise, CYC_RST=CLK_HZ*RESET_US/1e6; defaults give 25/8/16/6000.
REQ-016 SHALL accept a pixel on a clk20 edge where valid&&ready; valid with ready low is ignored and data is not stored.
REQ-017 SHALL store {latch_in,data_in} per entry; FIFO order preserved; push and pop on the same edge both take effect.
REQ-018 SHALL implement states IDLE, LOAD, BIT, LATCH.
REQ-019 IDLE: led=0; go to LOAD when FIFO non-empty.
REQ-020 LOAD: pop head into shift register; led=1 on next edge; enter BIT with bit index BITS_PER_PIXEL-1, counter 0.
REQ-021 BIT: counter increments each cycle; led falls when counter reaches CYC_1H-1 for a 1 bit, or CYC_0H-1 for a 0 bit.
REQ-022 Each bit cell SHALL be exactly CYC_P cycles high+low; the next bit's led rise follows immediately.
REQ-023 At the end of the last bit, if the entry latch flag is set: enter LATCH. Otherwise, if the FIFO is non-empty: pop and start the next pixel with no extra cycle (gapless). Otherwise: pulse underrun, go to IDLE.
REQ-024 LATCH: led=0 for exactly CYC_RST cycles, then IDLE; pushes are still accepted during LATCH.
REQ-025 First led rise SHALL occur exactly 2 cycles after the accepting edge when IDLE with FIFO empty.
REQ-026 led SHALL be glitch-free and driven only from a flop.

Reset
REQ-027 Asserting reset SHALL immediately force led=0, ready=0, busy=0, underrun=0, FIFO empty, state IDLE, all counters 0.
REQ-028 Reset mid-bit or mid-LATCH SHALL discard all pending pixels; ready SHALL return to 1 one cycle after reset deasserts.

Configuration
REQ-029 With WS2812_BRIGHTNESS_EN defined, each 8-bit channel c popped from the FIFO SHALL be sent as (c*(brightness+1))>>8, so brightness=255 is identity. brightness is sampled at LOAD/pop; latency per REQ-025 is unchanged.
REQ-030 Without WS2812_BRIGHTNESS_EN, the brightness port and multiplier SHALL be absent and data SHALL be sent unmodified.

Verification
REQ-031 Push 24'hFF0000 with latch=1 at defaults -> 8 cells of 16H/9L, then 16 cells of 8H/17L, then 6000 cycles low, then IDLE.
REQ-032 Push 4 pixels back-to-back with latch on the 4th -> 96 contiguous 25-cycle cells with no gap, ready never low while pushing at most DEPTH entries ahead.
REQ-033 Push 1 pixel with latch=0 and nothing after -> underrun pulses once at end of the 24th cell, led=0, busy=0.
REQ-034 Fill FIFO with DEPTH entries while in LATCH -> ready=0; further valid is ignored; entries are sent in order after LATCH.
REQ-035 Assert reset during the 10th bit -> led=0 asynchronously; after release, ready=1 and no residual pixel is sent.
REQ-036 With WS2812_BRIGHTNESS_EN and brightness=127, push 24'hFF8040 -> sent 24'h7F4020.

Source files
------------

// File: rtl/ws2812_stream_driver.sv
// WS2812 serial encoder fed by a pixel FIFO, with per-frame latch/reset gap.
// Define WS2812_BRIGHTNESS_EN to add the global brightness port and scaler.
module ws2812_stream_driver #(
    parameter int CLK_HZ         = 20000000,
    parameter int BITS_PER_PIXEL = 24,
    parameter int DEPTH          = 4,
    parameter int T0H_NS         = 400,
    parameter int T1H_NS         = 800,
    parameter int PERIOD_NS      = 1250,
    parameter int RESET_US       = 300
) (
    input  logic                      clk20,
    input  logic                      reset,
    input  logic [BITS_PER_PIXEL-1:0] data_in,
    input  logic                      latch_in,
    input  logic                      valid,
    output logic                      ready,
    output logic                      led,
    output logic                      busy,
    output logic                      underrun
`ifdef WS2812_BRIGHTNESS_EN
    ,
    input  logic [7:0]                brightness
`endif
);

    localparam int CYC_P   = int'((64'(CLK_HZ) * 64'(PERIOD_NS)) / 64'd1000000000);
    localparam int CYC_0H  = int'((64'(CLK_HZ) * 64'(T0H_NS)) / 64'd1000000000);
    localparam int CYC_1H  = int'((64'(CLK_HZ) * 64'(T1H_NS)) / 64'd1000000000);
    localparam int CYC_RST = int'((64'(CLK_HZ) * 64'(RESET_US)) / 64'd1000000);

    localparam int CNT_MAX = (CYC_RST > CYC_P) ? CYC_RST : CYC_P;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BIT_W   = $clog2(BITS_PER_PIXEL);
    localparam int AW      = $clog2(DEPTH);
    localparam int ENT_W   = BITS_PER_PIXEL + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BIT,
        S_LATCH
    } state_t;

    logic [ENT_W-1:0]          r_mem [DEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_count;
    logic                      r_rdy_en;

    state_t                    r_state;
    logic [BITS_PER_PIXEL-1:0] r_shift;
    logic                      r_latch;
    logic [BIT_W-1:0]          r_bit_idx;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_led;
    logic                      r_underrun;

    logic                      w_full;
    logic                      w_empty;
    logic                      w_push;
    logic                      w_pop;
    logic [ENT_W-1:0]          w_head;
    logic [BITS_PER_PIXEL-1:0] w_head_px;
    logic                      w_head_latch;
    logic [BITS_PER_PIXEL-1:0] w_load_px;
    logic                      w_cell_end;
    logic                      w_last_bit;
    logic [CNT_W-1:0]          w_high_end;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign ready    = r_rdy_en & ~w_full;
    assign w_push   = valid & ready;
    assign busy     = (r_state != S_IDLE) | ~w_empty;
    assign led      = r_led;
    assign underrun = r_underrun;

    assign w_head       = r_mem[r_rd_ptr];
    assign w_head_px    = w_head[BITS_PER_PIXEL-1:0];
    assign w_head_latch = w_head[BITS_PER_PIXEL];

`ifdef WS2812_BRIGHTNESS_EN
    logic [8:0] w_scale;
    assign w_scale = {1'b0, brightness} + 9'd1;

    for (genvar g = 0; g < BITS_PER_PIXEL / 8; g++) begin : g_ch
        assign w_load_px[g*8 +: 8] =
            8'((16'(w_head_px[g*8 +: 8]) * 16'(w_scale)) >> 8);
    end
`else
    assign w_load_px = w_head_px;
`endif

    assign w_cell_end = (r_cnt == CNT_W'(CYC_P - 1));
    assign w_last_bit = (r_bit_idx == '0);
    assign w_high_end = r_shift[BITS_PER_PIXEL-1] ? CNT_W'(CYC_1H - 1)
                                                  : CNT_W'(CYC_0H - 1);

    // A pop happens in LOAD or on a gapless hand-over at the final bit.
    assign w_pop = (r_state == S_LOAD) |
                   ((r_state == S_BIT) & w_cell_end & w_last_bit &
                    ~r_latch & ~w_empty);

    always_ff @(posedge clk20) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {latch_in, data_in};
        end
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk20 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_latch    <= 1'b0;
            r_bit_idx  <= '0;
            r_cnt      <= '0;
            r_led      <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_led <= 1'b0;
                    r_cnt <= '0;
                    if (!w_empty) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift   <= w_load_px;
                    r_latch   <= w_head_latch;
                    r_bit_idx <= BIT_W'(BITS_PER_PIXEL - 1);
                    r_cnt     <= '0;
                    r_led     <= 1'b1;
                    r_state   <= S_BIT;
                end
                S_BIT: begin
                    if (w_cell_end) begin
                        r_cnt <= '0;
                        if (!w_last_bit) begin
                            r_bit_idx <= r_bit_idx - BIT_W'(1);
                            r_shift   <= {r_shift[BITS_PER_PIXEL-2:0], 1'b0};
                            r_led     <= 1'b1;
                        end else if (r_latch) begin
                            r_led   <= 1'b0;
                            r_state <= S_LATCH;
                        end else if (!w_empty) begin
                            r_shift   <= w_load_px;
                            r_latch   <= w_head_latch;
                            r_bit_idx <= BIT_W'(BITS_PER_PIXEL - 1);
                            r_led     <= 1'b1;
                        end else begin
                            r_led      <= 1'b0;
                            r_underrun <= 1'b1;
                            r_state    <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == w_high_end) begin
                            r_led <= 1'b0;
                        end
                    end
                end
                S_LATCH: begin
                    r_led <= 1'b0;
                    if (r_cnt == CNT_W'(CYC_RST - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_led   <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// Bench for ws2812_stream_driver: a negedge monitor turns the led line into
// (high, low) cells, which are compared against cells derived from pixel bits.
module tb_ws2812_stream_driver;

    localparam int BPP    = 24;
    localparam int CLK_HZ = 20000000;
    localparam int P      = int'((64'(CLK_HZ) * 64'd1250) / 64'd1000000000);
    localparam int H0     = int'((64'(CLK_HZ) * 64'd400) / 64'd1000000000);
    localparam int H1     = int'((64'(CLK_HZ) * 64'd800) / 64'd1000000000);
    localparam int RST    = int'((64'(CLK_HZ) * 64'd300) / 64'd1000000);

    logic           clk20 = 1'b0;
    logic           reset;
    logic [BPP-1:0] data_in;
    logic           latch_in;
    logic           valid;
    logic           ready;
    logic           led;
    logic           busy;
    logic           underrun;
`ifdef WS2812_BRIGHTNESS_EN
    logic [7:0]     brightness;
`endif

    int n_chk = 0;
    int n_err = 0;

    ws2812_stream_driver dut (
        .clk20    (clk20),
        .reset    (reset),
        .data_in  (data_in),
        .latch_in (latch_in),
        .valid    (valid),
        .ready    (ready),
        .led      (led),
        .busy     (busy),
        .underrun (underrun)
`ifdef WS2812_BRIGHTNESS_EN
        ,
        .brightness (brightness)
`endif
    );

    always #5 clk20 = ~clk20;

    typedef struct {
        int h;
        int l;
        bit fin;
        bit u;
    } cell_t;

    cell_t cells[$];
    int    m_h = 0;
    int    m_l = 0;
    bit    m_in = 1'b0;
    int    n_urun = 0;

    // A cell closes at the next rise, or when busy drops while low.
    always @(negedge clk20) begin
        if (reset) begin
            m_in = 1'b0;
            m_h  = 0;
            m_l  = 0;
        end else if (led) begin
            if (m_in && m_l > 0) begin
                cells.push_back('{m_h, m_l, 1'b0, 1'b0});
                m_h = 0;
                m_l = 0;
            end
            m_in = 1'b1;
            m_h++;
        end else if (m_in) begin
            if (busy) begin
                m_l++;
            end else begin
                cells.push_back('{m_h, m_l, 1'b1, underrun});
                m_in = 1'b0;
                m_h  = 0;
                m_l  = 0;
            end
        end
        if (underrun === 1'b1) n_urun++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BPP-1:0] wire_px(input logic [BPP-1:0] d);
`ifdef WS2812_BRIGHTNESS_EN
        logic [BPP-1:0] r;
        for (int c = 0; c < BPP / 8; c++) begin
            r[c*8 +: 8] = 8'((int'(d[c*8 +: 8]) * (int'(brightness) + 1)) / 256);
        end
        return r;
`else
        return d;
`endif
    endfunction

    // Called at a negedge; drives one edge of valid and returns to a negedge.
    task automatic push(input logic [BPP-1:0] d, input logic l, output bit acc);
        data_in  = d;
        latch_in = l;
        valid    = 1'b1;
        acc      = ready;
        @(negedge clk20);
        valid    = 1'b0;
    endtask

    task automatic push_wait(input logic [BPP-1:0] d, input logic l,
                             input string tag);
        int w;
        bit acc;
        w = 0;
        while (!ready && w < 5000) begin
            @(negedge clk20);
            w++;
        end
        push(d, l, acc);
        chk({tag, "_accept"}, longint'(acc), 1);
    endtask

    // tail: 0 = latch then idle, 1 = underrun, 2 = latch then queued pixel
    task automatic check_frame(input logic [BPP-1:0] px[$], input int tail,
                               input string tag);
        int n;
        int w;
        n = px.size() * BPP;
        w = 0;
        while (cells.size() < n && w < n * P + RST + 2000) begin
            @(negedge clk20);
            w++;
        end
        chk({tag, "_cells"}, longint'(cells.size() >= n), 1);
        if (cells.size() < n) return;
        for (int i = 0; i < px.size(); i++) begin
            logic [BPP-1:0] got;
            got = '0;
            for (int b = BPP - 1; b >= 0; b--) begin
                cell_t c;
                int    eh;
                int    el;
                bit    last;
                c    = cells.pop_front();
                eh   = px[i][b] ? H1 : H0;
                last = (i == px.size() - 1) && (b == 0);
                el   = P - eh;
                if (last && tail == 0) el += RST;
                if (last && tail == 2) el += RST + 2;
                got[b] = (c.h == H1);
                chk({tag, "_high"}, c.h, eh);
                chk({tag, "_low"}, c.l, el);
                chk({tag, "_end"}, longint'(c.fin), longint'(last && tail != 2));
                chk({tag, "_urun"}, longint'(c.u), longint'(last && tail == 1));
            end
            chk({tag, "_pixel"}, got, px[i]);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [BPP-1:0] q[$];
        logic [BPP-1:0] d;
        logic [BPP-1:0] a;
        bit             acc;
        int             u0;
        int             w;
        int             nh;
        int             np;

        reset    = 1'b1;
        valid    = 1'b0;
        data_in  = '0;
        latch_in = 1'b0;
`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'd255;
`endif
        #1;
        chk("rst_led", led, 0);
        chk("rst_ready", ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_urun", underrun, 0);
        repeat (3) @(negedge clk20);
        reset = 1'b0;
        chk("rel_ready_low", ready, 0);
        @(negedge clk20);
        chk("rel_ready_up", ready, 1);

        // single red pixel with latch; first rise two edges after accept
        push(24'hFF0000, 1'b1, acc);
        chk("a_accept", longint'(acc), 1);
        chk("a_lat0", led, 0);
        @(negedge clk20);
        chk("a_lat1", led, 0);
        @(negedge clk20);
        chk("a_lat2", led, 1);
        q = '{};
        q.push_back(wire_px(24'hFF0000));
        check_frame(q, 0, "red");
        @(negedge clk20);
        chk("a_busy", busy, 0);
        chk("a_led", led, 0);

        // four back-to-back pixels, gapless
        q = '{};
        for (int i = 0; i < 4; i++) begin
            d = BPP'($urandom);
            push(d, 1'b1 ? (i == 3) : 1'b0, acc);
            chk("b_ready", longint'(acc), 1);
            q.push_back(wire_px(d));
        end
        check_frame(q, 0, "b2b");

        // underrun after a lone unlatched pixel
        u0 = n_urun;
        d  = BPP'($urandom);
        push(d, 1'b0, acc);
        chk("c_accept", longint'(acc), 1);
        q = '{};
        q.push_back(wire_px(d));
        check_frame(q, 1, "urun");
        repeat (3) @(negedge clk20);
        chk("c_urun_pulses", n_urun - u0, 1);
        chk("c_led", led, 0);
        chk("c_busy", busy, 0);

        // fill the FIFO during LATCH; the extra push must be dropped
        a = BPP'($urandom);
        push(a, 1'b1, acc);
        chk("d_accept_a", longint'(acc), 1);
        repeat (BPP * P + 50) @(negedge clk20);
        chk("d_in_latch_busy", busy, 1);
        q = '{};
        for (int i = 0; i < 4; i++) begin
            d = BPP'($urandom);
            push(d, (i == 3), acc);
            chk("d_fill_accept", longint'(acc), 1);
            q.push_back(wire_px(d));
        end
        chk("d_full", ready, 0);
        push(BPP'($urandom), 1'b1, acc);
        chk("d_reject", longint'(acc), 0);
        begin
            logic [BPP-1:0] qa[$];
            qa.push_back(wire_px(a));
            check_frame(qa, 2, "d_first");
        end
        check_frame(q, 0, "d_fill");
        repeat (100) @(negedge clk20);
        chk("d_no_extra", cells.size(), 0);
        chk("d_busy", busy, 0);

        // reset in the 10th bit discards everything pending
        push(BPP'($urandom), 1'b0, acc);
        push(BPP'($urandom), 1'b1, acc);
        w = 0;
        while (cells.size() < 9 && w < 1000) begin
            @(negedge clk20);
            w++;
        end
        chk("e_reached_bit10", longint'(cells.size() >= 9), 1);
        @(negedge clk20);
        #2;
        reset = 1'b1;
        #1;
        chk("e_led_async", led, 0);
        chk("e_ready", ready, 0);
        chk("e_busy", busy, 0);
        repeat (2) @(negedge clk20);
        reset = 1'b0;
        @(negedge clk20);
        chk("e_ready_up", ready, 1);
        cells.delete();
        nh = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk20);
            if (led) nh++;
        end
        chk("e_silent", nh, 0);
        chk("e_idle_busy", busy, 0);
        chk("e_no_cells", cells.size(), 0);

        // random latched frames, pushed as space frees
        for (int f = 0; f < 2; f++) begin
            np = $urandom_range(1, 5);
            q  = '{};
            for (int i = 0; i < np; i++) begin
                d = BPP'($urandom);
                push_wait(d, (i == np - 1), "f_push");
                q.push_back(wire_px(d));
            end
            check_frame(q, 0, "rand");
        end

`ifdef WS2812_BRIGHTNESS_EN
        brightness = 8'd127;
        push(24'hFF8040, 1'b1, acc);
        q = '{};
        q.push_back(24'h7F4020);
        check_frame(q, 0, "bright");
        brightness = 8'd255;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
